// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg: shared FSM states, command decode constants and display-RAM geometry for lcd_bus_rx
package lcd_bus_pkg;
    typedef enum logic [1:0] {IDLE, DECODE, CLEAR} state_t;
    localparam int RAM_DEPTH = 32;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02, HOME_MASK    = 8'hFE;
    localparam logic [7:0] CMD_ENTRY   = 8'h04, ENTRY_MASK   = 8'hFC;
    localparam logic [7:0] CMD_DISPCTL = 8'h08, DISPCTL_MASK = 8'hF8;
    localparam logic [7:0] CMD_SETADDR = 8'h80, SETADDR_MASK = 8'h80;
    localparam logic [6:0] LINE0_BASE  = 7'h00, LINE1_BASE   = 7'h40, LINE_MASK = 7'h70;
    function automatic logic cmd_is(input logic [7:0] b, input logic [7:0] op, input logic [7:0] mask);
        return (b & mask) == op;
    endfunction
endpackage

// File: rtl/lcd_bus_rx_if.sv
// lcd_bus_rx_if: LCD bus pins as driven by the bus master and observed by lcd_bus_rx
interface lcd_bus_rx_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] sf_d;
    modport master (output lcd_e, lcd_rs, lcd_rw, sf_d);
    modport slave  (input lcd_e, lcd_rs, lcd_rw, sf_d);
endinterface

// File: rtl/lcd_strobe_sync.sv
// lcd_strobe_sync: 2-flop synchronizes the LCD bus and accepts lcd_e falling edges after a minimum high time
module lcd_strobe_sync #(
    parameter int MIN_E_HIGH = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] d,
    output logic       acc,
    output logic       acc_rs,
    output logic       acc_rw,
    output logic [7:0] acc_d
);
    localparam int CW = $clog2(MIN_E_HIGH + 1);
    logic [10:0]   s1, s2;
    logic [CW-1:0] cnt;
    // cnt holds the saturated number of consecutive synchronized-high cycles of e
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
            {acc_rs, acc_rw, acc_d} <= '0;
            cnt <= '0;
        end else begin
            s1 <= {e, rs, rw, d};
            s2 <= s1;
            {acc_rs, acc_rw, acc_d} <= s2[9:0];
            cnt <= !s2[10] ? '0 : (cnt == CW'(MIN_E_HIGH)) ? cnt : cnt + 1'b1;
        end
    assign acc = !s2[10] && cnt == CW'(MIN_E_HIGH);
endmodule

// File: rtl/lcd_bus_rx.sv
// lcd_bus_rx: HD44780-style LCD bus receiver with 2x16 display RAM and command decode.
// Define LCD_NIBBLE_MODE_EN for a 4-bit bus on sf_d[7:4] (high nibble first).
module lcd_bus_rx
    import lcd_bus_pkg::*;
#(
    parameter int         MIN_E_HIGH = 2,
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        reset_n,
    lcd_bus_rx_if.slave bus,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_char,
    output logic        cmd_strobe,
    output logic        data_strobe,
    output logic [7:0]  rx_byte,
    output logic [4:0]  cursor,
    output logic        display_on,
    output logic        busy,
    output logic        err_addr,
    output logic        overrun,
    output logic        rd_seen
);
    state_t     state, state_nx;
    logic       acc, acc_rs, acc_rw, wr_acc, byte_rdy, go, rs_q, inc, we;
    logic [7:0] acc_d, rx_nx, wd;
    logic [4:0] wa, clr_idx;
    logic [7:0] ram [RAM_DEPTH];

    lcd_strobe_sync #(.MIN_E_HIGH(MIN_E_HIGH)) u_sync (
        .clk(clk), .reset_n(reset_n),
        .e(bus.lcd_e), .rs(bus.lcd_rs), .rw(bus.lcd_rw), .d(bus.sf_d),
        .acc(acc), .acc_rs(acc_rs), .acc_rw(acc_rw), .acc_d(acc_d)
    );

    assign wr_acc = acc && !acc_rw;
    assign busy   = state == CLEAR;

`ifdef LCD_NIBBLE_MODE_EN
    logic       phase;
    logic [3:0] hi_nib;
    // phase high means the next write strobe carries the high nibble
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            phase  <= 1'b1;
            hi_nib <= '0;
        end else if (wr_acc) begin
            phase <= !phase;
            if (phase) hi_nib <= acc_d[7:4];
        end
    assign byte_rdy = wr_acc && !phase;
    assign rx_nx    = {hi_nib, acc_d[7:4]};
`else
    assign byte_rdy = wr_acc;
    assign rx_nx    = acc_d;
`endif

    assign go = byte_rdy && state == IDLE;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;

    always_comb begin
        state_nx = state == IDLE   ? (go ? DECODE : IDLE) :
                   state == DECODE ? ((!rs_q && rx_byte == CMD_CLEAR) ? CLEAR : IDLE) :
                   (clr_idx == 5'(RAM_DEPTH - 1)) ? IDLE : CLEAR;
        we = busy || (state == DECODE && rs_q);
        wa = busy ? clr_idx : cursor;
        wd = busy ? CLEAR_CHAR : rx_byte;
    end

    always_ff @(posedge clk)
        if (we) ram[wa] <= wd;

    // non-blocking read alongside the fill write yields the pre-write value
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) rd_char <= '0;
        else          rd_char <= ram[rd_addr];

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cursor      <= '0;
            inc         <= 1'b1;
            display_on  <= 1'b0;
            cmd_strobe  <= 1'b0;
            data_strobe <= 1'b0;
            rx_byte     <= '0;
            rs_q        <= 1'b0;
            err_addr    <= 1'b0;
            overrun     <= 1'b0;
            rd_seen     <= 1'b0;
            clr_idx     <= '0;
        end else begin
            cmd_strobe  <= go && !acc_rs;
            data_strobe <= go && acc_rs;
            if (go) begin
                rx_byte <= rx_nx;
                rs_q    <= acc_rs;
            end
            if (acc && acc_rw) rd_seen <= 1'b1;
            if (wr_acc && state != IDLE) overrun <= 1'b1;
            clr_idx <= busy ? clr_idx + 1'b1 : '0;
            if (state == DECODE) begin
                if (rs_q) cursor <= inc ? cursor + 1'b1 : cursor - 1'b1;
                else if (rx_byte == CMD_CLEAR) begin
                    cursor <= '0;
                    inc    <= 1'b1;
                end
                else if (cmd_is(rx_byte, CMD_HOME, HOME_MASK)) cursor <= '0;
                else if (cmd_is(rx_byte, CMD_ENTRY, ENTRY_MASK)) inc <= rx_byte[1];
                else if (cmd_is(rx_byte, CMD_DISPCTL, DISPCTL_MASK)) display_on <= rx_byte[2];
                else if (cmd_is(rx_byte, CMD_SETADDR, SETADDR_MASK)) begin
                    if ((rx_byte[6:0] & LINE_MASK) == LINE0_BASE) cursor <= {1'b0, rx_byte[3:0]};
                    else if ((rx_byte[6:0] & LINE_MASK) == LINE1_BASE) cursor <= {1'b1, rx_byte[3:0]};
                    else err_addr <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_lcd_bus_rx.sv
// tb_lcd_bus_rx: directed bench for lcd_bus_rx with a strobe scoreboard; honours LCD_NIBBLE_MODE_EN.
module tb_lcd_bus_rx;
    logic       clk = 1'b0, reset_n = 1'b0;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_char, rx_byte, v;
    logic [4:0] cursor;
    logic       cmd_strobe, data_strobe, display_on, busy, err_addr, overrun, rd_seen;
    logic       busy_prev = 1'b0;
    logic [8:0] sb [$];
    logic [8:0] exp_e;
    int tests = 0, fails = 0, cyc = 0, busy_cnt = 0, busy_start = -1, clr_cyc = -1, dstrobes = 0, d0;

    lcd_bus_rx_if bus ();

    lcd_bus_rx dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .rd_addr(rd_addr), .rd_char(rd_char),
        .cmd_strobe(cmd_strobe), .data_strobe(data_strobe), .rx_byte(rx_byte), .cursor(cursor),
        .display_on(display_on), .busy(busy), .err_addr(err_addr), .overrun(overrun), .rd_seen(rd_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // scoreboard consumer and busy/strobe timing monitor
    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cnt++;
        if (busy && !busy_prev && busy_start < 0) busy_start = cyc;
        busy_prev = busy;
        if (cmd_strobe && rx_byte == 8'h01 && clr_cyc < 0) clr_cyc = cyc;
        if (data_strobe) dstrobes++;
        if (cmd_strobe || data_strobe) begin
            chk("strobe_expected", 32'(sb.size() > 0), 1);
            chk("strobe_exclusive", 32'(cmd_strobe && data_strobe), 0);
            if (sb.size() > 0) begin
                exp_e = sb.pop_front();
                chk("sb_rs_byte", {23'd0, data_strobe, rx_byte}, {23'd0, exp_e});
            end
        end
    end

    task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int hi, input int lo);
        @(negedge clk);
        bus.lcd_rs = rs;
        bus.lcd_rw = rw;
        bus.sf_d   = d;
        bus.lcd_e  = 1'b1;
        repeat (hi) @(negedge clk);
        bus.lcd_e = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b, input int hi, input int lo, input bit push);
        if (push) sb.push_back({rs, b});
`ifdef LCD_NIBBLE_MODE_EN
        strobe(rs, 1'b0, {b[7:4], 4'h0}, hi, lo);
        strobe(rs, 1'b0, {b[3:0], 4'h0}, hi, lo);
`else
        strobe(rs, 1'b0, b, hi, lo);
`endif
    endtask

    task automatic send(input logic rs, input logic [7:0] b);
        send_byte(rs, b, 4, 20, 1'b1);
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] val);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        val = rd_char;
    endtask

    initial begin
        bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.sf_d = '0;
        repeat (3) @(negedge clk);
        chk("rst_cursor", 32'(cursor), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_display_on", 32'(display_on), 0);
        chk("rst_strobes", 32'({cmd_strobe, data_strobe}), 0);
        chk("rst_flags", 32'({err_addr, overrun, rd_seen}), 0);
        chk("rst_rd_char", 32'(rd_char), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        send_byte(1'b0, 8'h01, 40, 60, 1'b1);
        chk("clear_busy_cycles", 32'(busy_cnt), 32);
        chk("clear_busy_start", 32'(busy_start - clr_cyc), 1);
        send_byte(1'b1, 8'h48, 40, 60, 1'b1);
        chk("cursor_after_48", 32'(cursor), 1);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), v);
            chk("ram_after_clear", 32'(v), (i == 0) ? 32'h48 : 32'h20);
        end

        send(1'b0, 8'h0C);
        chk("display_on", 32'(display_on), 1);

        send(1'b0, 8'hC5);
        send(1'b1, 8'h41);
        chk("cursor_after_c5", 32'(cursor), 22);
        rd(5'd21, v);
        chk("ram21", 32'(v), 32'h41);
        send(1'b0, 8'hA0);
        chk("err_addr", 32'(err_addr), 1);
        chk("cursor_bad_addr", 32'(cursor), 22);

        send(1'b0, 8'hCF);
        chk("cursor_cf", 32'(cursor), 31);
        send(1'b1, 8'h5A);
        chk("cursor_wrap_inc", 32'(cursor), 0);
        rd(5'd31, v);
        chk("ram31", 32'(v), 32'h5A);
        send(1'b0, 8'h04);
        send(1'b1, 8'h61);
        chk("cursor_wrap_dec", 32'(cursor), 31);
        send(1'b1, 8'h62);
        chk("cursor_dec", 32'(cursor), 30);
        rd(5'd0, v);
        chk("ram0_dec", 32'(v), 32'h61);
        rd(5'd31, v);
        chk("ram31_dec", 32'(v), 32'h62);
        send(1'b0, 8'h02);
        chk("cursor_home", 32'(cursor), 0);

        strobe(1'b1, 1'b0, 8'h77, 1, 20);
        chk("short_pulse_cursor", 32'(cursor), 0);
        rd(5'd0, v);
        chk("short_pulse_ram", 32'(v), 32'h61);

        chk("rd_seen_before", 32'(rd_seen), 0);
        strobe(1'b0, 1'b1, 8'hC8, 4, 20);
        chk("rd_seen", 32'(rd_seen), 1);
        chk("read_cursor", 32'(cursor), 0);

        chk("overrun_before", 32'(overrun), 0);
        busy_cnt = 0;
        send_byte(1'b0, 8'h01, 4, 6, 1'b1);
        send_byte(1'b1, 8'h99, 4, 6, 1'b0);
        repeat (40) @(negedge clk);
        chk("overrun", 32'(overrun), 1);
        chk("overrun_busy_cycles", 32'(busy_cnt), 32);
        chk("overrun_cursor", 32'(cursor), 0);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), v);
            chk("ram_after_overrun", 32'(v), 32'h20);
        end
        send(1'b1, 8'h33);
        chk("clear_sets_inc", 32'(cursor), 1);

        send_byte(1'b0, 8'h01, 4, 15, 1'b1);
        chk("busy_mid_clear", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("busy_async_reset", 32'(busy), 0);
        chk("overrun_reset", 32'(overrun), 0);
        chk("cursor_reset", 32'(cursor), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("busy_after_reset", 32'(busy), 0);

`ifdef LCD_NIBBLE_MODE_EN
        d0 = dstrobes;
        sb.push_back({1'b1, 8'h48});
        strobe(1'b1, 1'b0, 8'h40, 4, 20);
        strobe(1'b1, 1'b0, 8'h80, 4, 20);
        chk("nibble_one_strobe", 32'(dstrobes - d0), 1);
`endif

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lcd_bus_rx.md
LCD_BUS_RX -- requirements
Module: lcd_bus_rx

Interface
REQ-001 Parameter MIN_E_HIGH, default 2: minimum synchronized lcd_e high time, in clk cycles, for a strobe to count.
REQ-002 Parameter CLEAR_CHAR, default 8'h20: fill byte written to every display-RAM entry on a clear command.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 lcd_e  input  1  LCD enable strobe from the bus master.
REQ-006 lcd_rs  input  1  register select: 0 = command, 1 = data.
REQ-007 lcd_rw  input  1  1 = read request, 0 = write.
REQ-008 sf_d  input  8  LCD data bus.
REQ-009 rd_addr  input  5  display-RAM read index: {line, col[3:0]}.
REQ-010 rd_char  output  8  display-RAM byte at rd_addr, registered, 1-cycle latency.
REQ-011 cmd_strobe / data_strobe  output  1  one-cycle pulse per accepted command byte / data byte.
REQ-012 rx_byte  output  8  last accepted byte; valid while either strobe is high.
REQ-013 cursor  output  5  current display-RAM address.
REQ-014 display_on  output  1  D bit from the last display-control command.
REQ-015 busy  output  1  high while a clear operation is in progress.
REQ-016 err_addr, overrun, rd_seen  output  1 each  sticky flags, cleared only by reset.

Function
REQ-017 lcd_e, lcd_rs, lcd_rw and sf_d SHALL each pass through a 2-flop synchronizer, so all bus signals are delayed equally.
REQ-018 A strobe is accepted on the synchronized falling edge of lcd_e, and only when lcd_e was high for at least MIN_E_HIGH cycles; a shorter pulse is ignored silently.
REQ-019 rs, rw and data SHALL be taken from the synchronized values in the cycle before the falling edge.
REQ-020 For an accepted strobe with rw=1: rd_seen is set, no other state changes, no strobe pulses.
REQ-021 cmd_strobe or data_strobe SHALL pulse 1 cycle after the accepted edge.
REQ-022 Command 8'h01 (clear): writes CLEAR_CHAR to all 32 entries, one per cycle, sets cursor to 0, and sets the increment direction.
  - busy is high for exactly 32 cycles, starting the cycle after the strobe.
REQ-023 Commands 8'h02/8'h03 (home): cursor <= 0.
REQ-024 Commands 8'h04-8'h07 (entry mode): the direction flag takes bit1 (1 = increment).
REQ-025 Commands 8'h08-8'h0F: display_on takes bit2.
REQ-026 Commands 8'h80-8'hFF (set address): the 7-bit address A is decoded as follows.
  - A in 0x00-0x0F: cursor = {0, A[3:0]}.
  - A in 0x40-0x4F: cursor = {1, A[3:0]}.
  - Any other A: err_addr is set and cursor is unchanged.
REQ-027 All other command bytes SHALL be accepted (cmd_strobe pulses) with no further effect.
REQ-028 Data write: ram[cursor] <= byte, then cursor steps in the current direction.
  - Increment wraps 15 -> 16 and 31 -> 0.
  - Decrement wraps 0 -> 31 and 16 -> 15.
REQ-029 Any accepted write strobe while busy: the byte is dropped, overrun is set, no strobe pulses, and the clear continues.
REQ-030 A read and a clear-fill write to the same entry in the same cycle: rd_char shows the pre-write value.
REQ-031 State machine states:
  - IDLE: wait for an accepted strobe.
  - DECODE: one cycle; goes to CLEAR on 8'h01, otherwise back to IDLE.
  - CLEAR: 32 cycles, then IDLE.

Reset
REQ-032 On reset_n low, asynchronously:
  - state = IDLE, cursor = 0, direction = increment, display_on = 0.
  - All strobes and sticky flags = 0, busy = 0, rd_char = 0, synchronizers = 0.
REQ-033 Display-RAM contents are not reset; they are undefined until the first clear.
REQ-034 Reset asserted during CLEAR abandons the fill; after reset, busy = 0.

Configuration
REQ-035 Macro LCD_NIBBLE_MODE_EN selects the bus width.
  - Defined: 4-bit bus on sf_d[7:4]. Each byte takes two accepted write strobes, high nibble first. A nibble phase flag toggles per accepted write strobe; strobes with rw=1 do not toggle it. The byte is processed on the second strobe. Reset sets phase = high.
  - Undefined: 8-bit bus, one strobe per byte, and no phase flag exists.

Structure
REQ-036 A shared package lcd_bus_pkg SHALL hold:
  - the state enum;
  - command opcode/mask constants (CLEAR, HOME, ENTRY, DISPCTL, SETADDR);
  - line base addresses 0x00 and 0x40;
  - the RAM depth, 32.
REQ-037 The synchronizer plus E-width filter SHALL be a sub-module, lcd_strobe_sync.

Verification
REQ-038 Write 8'h01, then data 8'h48 at 1 MHz strobes: busy is high 32 cycles, then ram[0] = 8'h48, cursor = 1, and all other entries = 8'h20.
REQ-039 Command 8'hC5, then data 8'h41: ram[21] = 8'h41, cursor = 22.
  - Then command 8'hA0: err_addr = 1 and cursor stays 22.
REQ-040 Cursor at 31 with increment, data 8'h5A: ram[31] = 8'h5A, cursor = 0.
  - Then entry 8'h04 and two data bytes: cursor 0 -> 31 -> 30.
REQ-041 lcd_e pulse 1 cycle wide with MIN_E_HIGH = 2: no strobe and no state change.
  - A strobe with rw=1: rd_seen = 1, cursor unchanged.
REQ-042 Data strobe 10 cycles after 8'h01: overrun = 1, byte lost, clear still completes.
  - Then reset_n low mid-clear: busy = 0 immediately.
REQ-043 With LCD_NIBBLE_MODE_EN, nibbles 4'h4 then 4'h8 with rs=1: exactly one data_strobe, with rx_byte = 8'h48.
